// File: rtl/arbiter_rr.sv
// arbiter_rr: round-robin burst arbiter muxing NUM_SLV slave beat streams into one FIFO push port.
// Define ARB_PERF_CNT_EN to add saturating per-slave accept counters on perf_cnt.
module arbiter_rr #(
  parameter int DW = 32,
  parameter int NUM_SLV = 4,
  parameter int BURST_LEN = 16,
  localparam int SW = $clog2(NUM_SLV)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NUM_SLV-1:0]   slv_mode,
  input  logic [NUM_SLV-1:0]     slv_data_valid,
  input  logic [DW*NUM_SLV-1:0]  slv_data,
  input  logic [8*NUM_SLV-1:0]   slv_proc_valid,
  output logic [NUM_SLV-1:0]     slv_ready,
  input  logic                   fifo_full,
  input  logic                   mstr_cmplt,
  output logic [1:0]             slvx_mode,
  output logic [DW-1:0]          slvx_data,
  output logic [7:0]             slvx_proc_val,
  output logic                   slvx_data_valid,
`ifdef ARB_PERF_CNT_EN
  output logic [SW-1:0]          data_source,
  output logic [16*NUM_SLV-1:0]  perf_cnt
`else
  output logic [SW-1:0]          data_source
`endif
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [SW-1:0] gnt_idx, rr_ptr, nxt_ptr, srch, off, sel;
  logic [SW:0] sum;
  logic [7:0] beat_cnt;
  logic [NUM_SLV-1:0] req, rot;
  logic [NUM_SLV-1:0][1:0] mode_v;
  logic [NUM_SLV-1:0][DW-1:0] data_v;
  logic [NUM_SLV-1:0][7:0] proc_v;
  logic rdy, acc, done;
  assign mode_v = slv_mode;
  assign data_v = slv_data;
  assign proc_v = slv_proc_valid;
  always_comb begin
    for (int i = 0; i < NUM_SLV; i++) req[i] = |mode_v[i];
  end
  assign rdy = state == GRANT && !fifo_full && !mstr_cmplt && req[gnt_idx];
  assign acc = rdy && slv_data_valid[gnt_idx];
  always_comb begin
    for (int i = 0; i < NUM_SLV; i++) slv_ready[i] = rdy && gnt_idx == SW'(i);
  end
  // a burst ends on its last accepted beat or as soon as the granted slave stops requesting
  assign done = state == GRANT && (!req[gnt_idx] || (acc && beat_cnt == 8'(BURST_LEN - 1)));
  assign nxt_ptr = gnt_idx == SW'(NUM_SLV - 1) ? '0 : gnt_idx + SW'(1);
  assign srch = state == GRANT ? nxt_ptr : rr_ptr;
  // rotate so bit 0 is the search start; the lowest set bit is the winner's offset
  always_comb begin
    rot = NUM_SLV'({req, req} >> srch);
    off = '0;
    for (int k = NUM_SLV - 1; k >= 0; k--) if (rot[k]) off = SW'(k);
  end
  assign sum = {1'b0, srch} + {1'b0, off};
  assign sel = sum >= (SW+1)'(NUM_SLV) ? SW'(sum - (SW+1)'(NUM_SLV)) : SW'(sum);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_idx <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      slvx_mode <= '0;
      slvx_data <= '0;
      slvx_proc_val <= '0;
      slvx_data_valid <= 1'b0;
      data_source <= '0;
    end else begin
      slvx_data_valid <= acc;
      if (acc) begin
        slvx_mode <= mode_v[gnt_idx];
        slvx_data <= data_v[gnt_idx];
        slvx_proc_val <= proc_v[gnt_idx];
        data_source <= gnt_idx;
      end
      if (mstr_cmplt) state <= IDLE;
      else if (state == IDLE || done) begin
        if (done) rr_ptr <= nxt_ptr;
        state <= |req ? GRANT : IDLE;
        gnt_idx <= |req ? sel : gnt_idx;
        beat_cnt <= '0;
      end else if (acc) beat_cnt <= beat_cnt + 8'd1;
    end
  end
`ifdef ARB_PERF_CNT_EN
  logic [NUM_SLV-1:0][15:0] pc;
  assign perf_cnt = pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else for (int i = 0; i < NUM_SLV; i++) if (acc && gnt_idx == SW'(i) && pc[i] != 16'hFFFF) pc[i] <= pc[i] + 16'd1;
  end
`else
`endif
endmodule
